branch_tracker: RTL and testbench

Tracks every in-flight conditional branch from fetch-time prediction to execute-time resolution, then drives the branch history table's update port (`right` / `wrong` / `index_bht2`). It also raises a fetch redirect on a misprediction. It sits between instruction fetch (which reads the table's `bht_re`) and the branch ALU. Branches resolve in program order, so the tracker is a FIFO of predictions with compare-and-retire logic at its head.

---
 rtl/branch_tracker_pkg.sv | 18 +
 rtl/branch_fifo.sv | 58 +++++
 rtl/branch_tracker.sv | 103 ++++++++++
 tb/tb_branch_tracker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_tracker_pkg.sv
// Shared definitions for the branch tracker: default sizes and the packed
// in-flight entry layout {index, pred, pc, target}, target in the low bits.
package branch_tracker_pkg;

   localparam int PC_W      = 32;
   localparam int IDX_W_DEF = 8;
   localparam int DEPTH_DEF = 8;

   localparam int TGT_LSB  = 0;
   localparam int PC_LSB   = TGT_LSB + PC_W;
   localparam int PRED_BIT = PC_LSB + PC_W;
   localparam int IDX_LSB  = PRED_BIT + 1;

   function automatic int entry_w(input int idx_w);
      return IDX_LSB + idx_w;
   endfunction

endpackage

// File: rtl/branch_fifo.sv
// DEPTH-entry synchronous FIFO with push, pop and a single-cycle clear that
// wins over push. Everything holds while en is low.
module branch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap modulo DEPTH; count tells full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (en) begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en && do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/branch_tracker.sv
// In-flight branch tracker: FIFO of predictions, compare-and-retire at the head,
// registered BHT update pulses and redirect. Optional stats: BRANCH_TRACKER_STATS_EN.
module branch_tracker
   import branch_tracker_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rdy,
   input  logic                   alloc_valid,
   output logic                   alloc_ready,
   input  logic [PC_W-1:0]        alloc_pc,
   input  logic                   alloc_pred,
   input  logic [PC_W-1:0]        alloc_target,
   input  logic                   res_valid,
   input  logic                   res_taken,
   output logic                   right,
   output logic                   wrong,
   output logic [IDX_W-1:0]       index_bht2,
   output logic                   redirect_valid,
   output logic [PC_W-1:0]        redirect_pc,
   output logic [$clog2(DEPTH):0] count
`ifdef BRANCH_TRACKER_STATS_EN
   ,
   output logic [31:0]            stat_right,
   output logic [31:0]            stat_wrong
`endif
);

   localparam int EW = entry_w(IDX_W);

   // Handshake: an alloc transfers on a rdy-high edge where alloc_valid and
   // alloc_ready are both 1; alloc_ready depends only on registered count.
   logic [EW-1:0]    alloc_entry;
   logic [EW-1:0]    head;
   logic             full;
   logic             empty;
   logic             resolve;
   logic             hit;
   logic [IDX_W-1:0] head_idx;
   logic             head_pred;
   logic [PC_W-1:0]  head_pc;
   logic [PC_W-1:0]  head_tgt;

   assign alloc_entry = {alloc_pc[IDX_W+1:2], alloc_pred, alloc_pc, alloc_target};
   assign head_idx    = head[IDX_LSB +: IDX_W];
   assign head_pred   = head[PRED_BIT];
   assign head_pc     = head[PC_LSB +: PC_W];
   assign head_tgt    = head[TGT_LSB +: PC_W];

   assign alloc_ready = !full;
   assign resolve     = res_valid && !empty;
   assign hit         = (res_taken == head_pred);

   // A mispredict clears the queue; clear beats push so a same-cycle alloc is dropped.
   branch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (rdy),
      .push  (alloc_valid),
      .pop   (resolve && hit),
      .clear (resolve && !hit),
      .din   (alloc_entry),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         right          <= 1'b0;
         wrong          <= 1'b0;
         redirect_valid <= 1'b0;
         index_bht2     <= '0;
         redirect_pc    <= '0;
      end else if (rdy) begin
         right          <= resolve && hit;
         wrong          <= resolve && !hit;
         redirect_valid <= resolve && !hit;
         if (resolve) index_bht2 <= head_idx;
         if (resolve && !hit) redirect_pc <= res_taken ? head_tgt : head_pc + 32'd4;
      end
   end

`ifdef BRANCH_TRACKER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_right <= '0;
         stat_wrong <= '0;
      end else if (rdy && resolve) begin
         if (hit) stat_right <= stat_right + 32'd1;
         else     stat_wrong <= stat_wrong + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_tracker.sv
// Directed bench for branch_tracker: queue-based reference model checked every
// cycle, plus literal expectations from the test plan.
module tb_branch_tracker;

   localparam int DEPTH = 8;
   localparam int IDX_W = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        alloc_valid = 1'b0;
   logic        alloc_ready;
   logic [31:0] alloc_pc = '0;
   logic        alloc_pred = 1'b0;
   logic [31:0] alloc_target = '0;
   logic        res_valid = 1'b0;
   logic        res_taken = 1'b0;
   logic        right;
   logic        wrong;
   logic [7:0]  index_bht2;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [3:0]  count;
`ifdef BRANCH_TRACKER_STATS_EN
   logic [31:0] stat_right;
   logic [31:0] stat_wrong;
`endif

   branch_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_pc       (alloc_pc),
      .alloc_pred     (alloc_pred),
      .alloc_target   (alloc_target),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .right          (right),
      .wrong          (wrong),
      .index_bht2     (index_bht2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .count          (count)
`ifdef BRANCH_TRACKER_STATS_EN
      ,
      .stat_right     (stat_right),
      .stat_wrong     (stat_wrong)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard counters and check ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic        pred;
      logic [31:0] target;
   } ent_t;

   ent_t        mq[$];
   ent_t        h;
   bit          m_acc;
   bit          m_res;
   logic        m_right = 1'b0;
   logic        m_wrong = 1'b0;
   logic        m_rv = 1'b0;
   logic [7:0]  m_idx = '0;
   logic [31:0] m_rpc = '0;
   logic [31:0] m_sr = '0;
   logic [31:0] m_sw = '0;

   always @(negedge rst_n) begin
      mq.delete();
      m_right = 0; m_wrong = 0; m_rv = 0; m_idx = 0; m_rpc = 0; m_sr = 0; m_sw = 0;
   end

   always @(posedge clk) begin
      if (rst_n && rdy) begin
         m_acc   = alloc_valid && (mq.size() < DEPTH);
         m_res   = res_valid && (mq.size() > 0);
         m_right = 0;
         m_wrong = 0;
         m_rv    = 0;
         if (m_res) begin
            h     = mq[0];
            m_idx = h.pc[9:2];
            if (h.pred == res_taken) begin
               m_right = 1;
               m_sr++;
               void'(mq.pop_front());
            end else begin
               m_wrong = 1;
               m_rv    = 1;
               m_sw++;
               m_rpc   = res_taken ? h.target : h.pc + 32'd4;
               mq.delete();
               m_acc   = 0;
            end
         end
         if (m_acc) mq.push_back('{pc: alloc_pc, pred: alloc_pred, target: alloc_target});
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("right", {31'b0, right}, {31'b0, m_right});
         chk("wrong", {31'b0, wrong}, {31'b0, m_wrong});
         chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
         chk("index_bht2", {24'b0, index_bht2}, {24'b0, m_idx});
         chk("redirect_pc", redirect_pc, m_rpc);
         chk("count", {28'b0, count}, mq.size());
         chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, (mq.size() != DEPTH)});
`ifdef BRANCH_TRACKER_STATS_EN
         chk("stat_right", stat_right, m_sr);
         chk("stat_wrong", stat_wrong, m_sw);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic av, input logic [31:0] pc, input logic pr,
                        input logic [31:0] tg, input logic rv, input logic rt);
      @(negedge clk);
      alloc_valid  = av;
      alloc_pc     = pc;
      alloc_pred   = pr;
      alloc_target = tg;
      res_valid    = rv;
      res_taken    = rt;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic alloc(input logic [31:0] pc, input logic pr, input logic [31:0] tg);
      drive(1'b1, pc, pr, tg, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic rt);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rt);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      #1;
      chk("rst_count", {28'b0, count}, 32'd0);
      chk("rst_alloc_ready", {31'b0, alloc_ready}, 32'd1);
      chk("rst_right", {31'b0, right}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // 1: correct prediction
      alloc(32'h100, 1'b1, 32'h200);
      resolve(1'b1);
      idle();
      chk("t1_right", {31'b0, right}, 32'd1);
      chk("t1_index", {24'b0, index_bht2}, 32'h40);
      chk("t1_redirect", {31'b0, redirect_valid}, 32'd0);
      chk("t1_count", {28'b0, count}, 32'd0);

      // 2: mispredict, fall-through redirect
      alloc(32'h104, 1'b1, 32'h300);
      resolve(1'b0);
      idle();
      chk("t2_wrong", {31'b0, wrong}, 32'd1);
      chk("t2_index", {24'b0, index_bht2}, 32'h41);
      chk("t2_redirect_valid", {31'b0, redirect_valid}, 32'd1);
      chk("t2_redirect_pc", redirect_pc, 32'h108);
      idle();
      chk("t2_wrong_cleared", {31'b0, wrong}, 32'd0);

      // 3: full queue, refused allocs, no pop bypass
      for (int i = 0; i < 8; i++) alloc(32'h200 + 32'(4 * i), 1'b1, 32'h1000);
      alloc(32'h400, 1'b1, 32'h1000);
      chk("t3_full_ready", {31'b0, alloc_ready}, 32'd0);
      chk("t3_full_count", {28'b0, count}, 32'd8);
      drive(1'b1, 32'h500, 1'b1, 32'h1000, 1'b1, 1'b1);
      chk("t3_ninth_refused", {28'b0, count}, 32'd8);
      idle();
      chk("t3_count7", {28'b0, count}, 32'd7);
      chk("t3_right", {31'b0, right}, 32'd1);
      chk("t3_index", {24'b0, index_bht2}, 32'h80);
      resolve(1'b0);
      idle();
      chk("t3_flush_count", {28'b0, count}, 32'd0);
      chk("t3_flush_pc", redirect_pc, 32'h208);

      // 4: mispredict with simultaneous alloc, then resolve on empty
      for (int i = 0; i < 3; i++) alloc(32'h600 + 32'(4 * i), 1'b0, 32'h700);
      drive(1'b1, 32'h60c, 1'b0, 32'h700, 1'b1, 1'b1);
      chk("t4_count3", {28'b0, count}, 32'd3);
      idle();
      chk("t4_count0", {28'b0, count}, 32'd0);
      chk("t4_wrong", {31'b0, wrong}, 32'd1);
      chk("t4_redirect_pc", redirect_pc, 32'h700);
      resolve(1'b1);
      idle();
      chk("t4_empty_right", {31'b0, right}, 32'd0);
      chk("t4_empty_wrong", {31'b0, wrong}, 32'd0);

      // 5: pulse held through a rdy stall
      alloc(32'h800, 1'b0, 32'h900);
      resolve(1'b0);
      idle();
      rdy = 1'b0;
      chk("t5_right_stall0", {31'b0, right}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_right_stall", {31'b0, right}, 32'd1);
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("t5_right_cleared", {31'b0, right}, 32'd0);
`ifdef BRANCH_TRACKER_STATS_EN
      chk("t5_stat_right", stat_right, 32'd3);
      chk("t5_stat_wrong", stat_wrong, 32'd3);
`endif

      // 6: asynchronous reset mid-operation
      for (int i = 0; i < 6; i++) alloc(32'ha00 + 32'(4 * i), 1'b1, 32'hb00);
      resolve(1'b1);
      idle();
      chk("t6_count5", {28'b0, count}, 32'd5);
      chk("t6_right", {31'b0, right}, 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count", {28'b0, count}, 32'd0);
      chk("t6_rst_ready", {31'b0, alloc_ready}, 32'd1);
      chk("t6_rst_right", {31'b0, right}, 32'd0);
      chk("t6_rst_index", {24'b0, index_bht2}, 32'd0);
      chk("t6_rst_redirect_pc", redirect_pc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // PC wrap on fall-through redirect
      alloc(32'hffff_fffc, 1'b1, 32'h40);
      resolve(1'b0);
      idle();
      chk("wrap_redirect_pc", redirect_pc, 32'h0);
      chk("wrap_index", {24'b0, index_bht2}, 32'hff);

      idle();
      idle();
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
